// File: rtl/shiftreg_ctrl_pkg.sv
// Shared encodings for the shift register command sequencer.
// Command opcodes, FSM states and shift directions.
package shiftreg_ctrl_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_DRAIN = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_CLEAR
  } state_t;

endpackage

// File: rtl/shiftreg_ctrl_bit_counter.sv
// Bit counter for the sequencer: clear, increment,
// and a terminal flag on the last bit position.
module bit_counter #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          term
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

  assign term = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/shiftreg_ctrl.sv
// Command sequencer driving a serial shift register:
// LOAD shifts a word in MSB-first, DRAIN streams it out LSB-first.
module shiftreg_ctrl
  import shiftreg_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] sr_q,
  output logic             sr_d,
  output logic             sr_en,
  output logic             sr_dir,
  output logic             sr_rst,
  output logic             ser_valid,
  output logic             ser_bit,
  input  logic             ser_ready,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] hold;
  logic             done_n;
  logic             accept;
  logic             cnt_inc;
  logic [CW-1:0]    count;
  logic             term;
  logic             sr_q_unused;

  assign cmd_ready   = (state == S_IDLE) && !rst;
  assign accept      = cmd_valid && cmd_ready;
  assign busy        = (state != S_IDLE);
  assign sr_rst      = rst || (state == S_CLEAR);
  assign sr_q_unused = ^sr_q[WIDTH-1:1];

  assign cnt_inc = (state == S_LOAD) ||
                   ((state == S_DRAIN) && ser_ready);

  bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   (cnt_inc),
    .count (count),
    .term  (term)
  );

  // hold shifts with the register, so its MSB is always the next bit in
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      hold  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= done_n;
      if (accept && (cmd_op == OP_LOAD)) begin
        hold <= cmd_data;
      end else if (state == S_LOAD) begin
        hold <= {hold[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    state_n   = state;
    done_n    = 1'b0;
    sr_en     = 1'b0;
    sr_d      = 1'b0;
    sr_dir    = DIR_LEFT;
    ser_valid = 1'b0;
    ser_bit   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_LOAD:  state_n = S_LOAD;
            OP_DRAIN: state_n = S_DRAIN;
            OP_CLEAR: state_n = S_CLEAR;
            default:  done_n  = 1'b1;
          endcase
        end
      end
      S_LOAD: begin
        sr_en = !rst;
        sr_d  = hold[WIDTH-1];
        if (term) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end
      S_DRAIN: begin
        ser_valid = !rst;
        ser_bit   = sr_q[0];
        sr_dir    = DIR_RIGHT;
        sr_en     = !rst && ser_ready;
        if (ser_ready && term) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end
      S_CLEAR: begin
        state_n = S_IDLE;
        done_n  = 1'b1;
      end
    endcase
  end

endmodule
